// File: rtl/execute_data_feeder_if.sv
// rtl/execute_data_feeder_if.sv - FIFO read port and packed output stream of the execute data feeder
interface execute_data_feeder_if #(
    parameter int WIDTH  = 32,
    parameter int SCALER = 2
) ();
    logic                    fifo_rd_en;
    logic [WIDTH-1:0]        fifo_dout;
    logic                    fifo_empty;
    logic [WIDTH*SCALER-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;

    modport master (
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_empty,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_empty,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last
    );
endinterface

// File: rtl/execute_data_feeder.sv
// rtl/execute_data_feeder.sv - drains the execute data FIFO, packs SCALER words per beat, streams a counted burst
module execute_data_feeder #(
    parameter int WIDTH  = 32,
    parameter int SCALER = 2,
    parameter int LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     burst_len,
    output logic                 busy,
    output logic                 done,
    execute_data_feeder_if.master bus
);
    localparam int CNT_W = $clog2(SCALER + 1);
    localparam int WL_W  = LEN_W + $clog2(SCALER) + 1;
    localparam int BW    = WIDTH * SCALER;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WL_W-1:0]   words_left;
    logic [LEN_W-1:0]  beats_left;
    logic [CNT_W-1:0]  reserved;
    logic [CNT_W-1:0]  landed;
    logic              rd_en_d;
    logic [BW-1:0]     pack;
    logic [BW-1:0]     data_q;
    logic              valid_q;
    logic              last_q;
    logic              pack_xfer;
    logic              rd_en;
    logic              out_hs;

    assign out_hs    = valid_q && bus.out_ready;
    assign pack_xfer = (state == RUN) && (landed == CNT_W'(SCALER)) && (!valid_q || bus.out_ready);

    // A slot is reserved at issue time, so a word still in flight always has a place to land.
    assign rd_en = (state == RUN) && !bus.fifo_empty && (words_left != '0)
                && ((reserved < CNT_W'(SCALER)) || pack_xfer);

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_data   = data_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_last   = last_q;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (burst_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (out_hs && last_q) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_left <= '0;
            beats_left <= '0;
            reserved   <= '0;
            landed     <= '0;
            rd_en_d    <= 1'b0;
            pack       <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            rd_en_d <= rd_en;

            if ((state == IDLE) && start) begin
                words_left <= WL_W'(burst_len) * WL_W'(SCALER);
            end else if (rd_en) begin
                words_left <= words_left - WL_W'(1);
            end

            if (pack_xfer) begin
                reserved <= rd_en ? CNT_W'(1) : '0;
            end else if (rd_en) begin
                reserved <= reserved + CNT_W'(1);
            end

            // The issuing word is counted in reserved; it bumps landed only once it arrives.
            if (pack_xfer) begin
                landed <= '0;
            end else if (rd_en_d) begin
                landed <= landed + CNT_W'(1);
            end

            for (int k = 0; k < SCALER; k++) begin
                if (rd_en_d && (landed == CNT_W'(k))) begin
                    pack[k*WIDTH +: WIDTH] <= bus.fifo_dout;
                end
            end

            if ((state == IDLE) && start) begin
                beats_left <= burst_len;
            end else if (pack_xfer) begin
                beats_left <= beats_left - LEN_W'(1);
            end

            if (pack_xfer) begin
                data_q  <= pack;
                valid_q <= 1'b1;
                last_q  <= (beats_left == LEN_W'(1));
            end else if (out_hs) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end
endmodule
